// File: rtl/chan_sel_seq.sv
// chan_sel_seq: registered N-channel, W-bit selector with manual and scan modes
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   ch_data   in   N*W packed channels, channel k = ch_data[k*W +: W]
//   en        in   block enable (0 = idle)
//   mode      in   0 = manual (sel picks channel), 1 = scan (sequencer)
//   sel       in   manual-mode channel index
//   g         out  registered selected data
//   g_valid   out  g holds a legal selection from the last edge
//   cur_sel   out  channel currently driving g
//   sel_err   out  one-cycle pulse: manual sel >= N (or stuck-bus when enabled)
//   scan_wrap out  one-cycle pulse: scan wrapped from N-1 to 0
//   g_par     out  even parity of g (only with CHAN_SEL_PARITY_EN)
// Optional feature macro: CHAN_SEL_PARITY_EN adds g_par and the all-ones stuck-bus check.
module chan_sel_seq #(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int DWELL = 2,
    parameter int SW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  ch_data,
    input  logic            en,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    g,
    output logic            g_valid,
    output logic [SW-1:0]   cur_sel,
    output logic            sel_err,
    output logic            scan_wrap
`ifdef CHAN_SEL_PARITY_EN
    ,
    output logic            g_par
`endif
);
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   g_q, g_d;
    logic           g_valid_q, g_valid_d;
    logic [SW-1:0]  cur_sel_q, cur_sel_d;
    logic           sel_err_q, sel_err_d;
    logic           scan_wrap_q, scan_wrap_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           par_q, par_d;
    logic           load;
    logic           sel_ok;
    logic           last_ch;

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
        pick = '0;
        for (int k = 0; k < N; k++)
            if (idx == SW'(k)) pick = d[k*W +: W];
    endfunction

    always_comb begin
        state_d     = !en ? IDLE : (mode ? SCAN : MANUAL);
        sel_ok      = sel <= SW'(N - 1);
        last_ch     = cur_sel_q == SW'(N - 1);
        cur_sel_d   = cur_sel_q;
        g_valid_d   = 1'b0;
        sel_err_d   = 1'b0;
        scan_wrap_d = 1'b0;
        dwell_d     = '0;
        load        = 1'b0;
        case (state_d)
            MANUAL: begin
                cur_sel_d = sel_ok ? sel : cur_sel_q;
                load      = sel_ok;
                g_valid_d = sel_ok;
                sel_err_d = !sel_ok;
            end
            SCAN: begin
                load      = 1'b1;
                g_valid_d = 1'b1;
                // entering scan always restarts at channel 0 with a fresh dwell
                if (state_q != SCAN) begin
                    cur_sel_d = '0;
                end else if (dwell_q == DW'(DWELL - 1)) begin
                    cur_sel_d   = last_ch ? '0 : cur_sel_q + 1'b1;
                    scan_wrap_d = last_ch;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: ;
        endcase
        // g follows the channel that cur_sel will name after this edge
        g_d   = load ? pick(ch_data, cur_sel_d) : g_q;
        par_d = load ? ^g_d : par_q;
`ifdef CHAN_SEL_PARITY_EN
        sel_err_d = sel_err_d | (state_d == MANUAL && sel_ok && &g_d);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            g_valid_q   <= 1'b0;
            cur_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
            dwell_q     <= '0;
            par_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            g_valid_q   <= g_valid_d;
            cur_sel_q   <= cur_sel_d;
            sel_err_q   <= sel_err_d;
            scan_wrap_q <= scan_wrap_d;
            dwell_q     <= dwell_d;
            par_q       <= par_d;
        end
    end

    assign g         = g_q;
    assign g_valid   = g_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;
    assign scan_wrap = scan_wrap_q;
`ifdef CHAN_SEL_PARITY_EN
    assign g_par = par_q;
`else
    logic unused_par;
    assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_chan_sel_seq.sv
// tb_chan_sel_seq: directed and random checks of chan_sel_seq against a behavioural model
module tb_chan_sel_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, mode;
    logic [1:0]  sel;
    logic [15:0] da;
    logic [11:0] db;
    logic [3:0]  ga, gb;
    logic        va, vb, ea, eb, wa, wb;
    logic [1:0]  ca, cb;
`ifdef CHAN_SEL_PARITY_EN
    logic        pa, pb;
`endif

    int n_asrt = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] g;
        logic       v;
        logic [1:0] cur;
        logic       err;
        logic       wrap;
        logic       par;
        bit         sc;
        int         t;
    } m_t;

    m_t ma, mb;

    always #5 clk = ~clk;

    chan_sel_seq #(.W(4), .N(4), .DWELL(2)) dut_a (
        .clk(clk), .rst(rst), .ch_data(da), .en(en), .mode(mode), .sel(sel),
        .g(ga), .g_valid(va), .cur_sel(ca), .sel_err(ea), .scan_wrap(wa)
`ifdef CHAN_SEL_PARITY_EN
        , .g_par(pa)
`endif
    );

    chan_sel_seq #(.W(4), .N(3), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .ch_data(db), .en(en), .mode(mode), .sel(sel),
        .g(gb), .g_valid(vb), .cur_sel(cb), .sel_err(eb), .scan_wrap(wb)
`ifdef CHAN_SEL_PARITY_EN
        , .g_par(pb)
`endif
    );

    function automatic m_t m_rst();
        m_t m;
        m.g = '0; m.v = 0; m.cur = '0; m.err = 0; m.wrap = 0; m.par = 0; m.sc = 0; m.t = 0;
        return m;
    endfunction

    // Scan position is derived from elapsed scan cycles: channel = (t / dwell) % n.
    function automatic m_t step(m_t m, int n, int dw, logic [63:0] d, logic e, logic md, logic [1:0] s);
        m.err = 0;
        m.wrap = 0;
        if (!e) begin
            m.v = 0;
            m.sc = 0;
        end else if (!md) begin
            m.sc = 0;
            if (int'(s) < n) begin
                m.cur = s;
                m.g = d[int'(s)*4 +: 4];
                m.par = ^m.g;
                m.v = 1;
`ifdef CHAN_SEL_PARITY_EN
                m.err = (m.g == 4'hF);
`endif
            end else begin
                m.v = 0;
                m.err = 1;
            end
        end else begin
            m.t = m.sc ? m.t + 1 : 0;
            m.sc = 1;
            m.cur = 2'((m.t / dw) % n);
            m.g = d[int'(m.cur)*4 +: 4];
            m.par = ^m.g;
            m.v = 1;
            m.wrap = (m.t > 0) && (m.t % (dw * n) == 0);
        end
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_g", 32'(ga), 32'(ma.g));
        chk("a_valid", 32'(va), 32'(ma.v));
        chk("a_cur", 32'(ca), 32'(ma.cur));
        chk("a_err", 32'(ea), 32'(ma.err));
        chk("a_wrap", 32'(wa), 32'(ma.wrap));
        chk("b_g", 32'(gb), 32'(mb.g));
        chk("b_valid", 32'(vb), 32'(mb.v));
        chk("b_cur", 32'(cb), 32'(mb.cur));
        chk("b_err", 32'(eb), 32'(mb.err));
        chk("b_wrap", 32'(wb), 32'(mb.wrap));
`ifdef CHAN_SEL_PARITY_EN
        chk("a_par", 32'(pa), 32'(ma.par));
        chk("b_par", 32'(pb), 32'(mb.par));
`endif
    endtask

    task automatic tick();
        ma = step(ma, 4, 2, 64'(da), en, mode, sel);
        mb = step(mb, 3, 3, 64'(db), en, mode, sel);
        @(posedge clk);
        #1;
        check_all();
    endtask

    int seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [3:0] held;

    initial begin
        rst = 1; en = 0; mode = 0; sel = 0; da = '0; db = '0;
        ma = m_rst(); mb = m_rst();
        #12;
        check_all();
        rst = 0;

        en = 1; mode = 0; da = 16'h8421; db = 12'h521; sel = 2;
        tick();
        chk("tp_sel2_g", 32'(ga), 32'h4);
        chk("tp_sel2_cur", 32'(ca), 32'h2);
        chk("tp_sel2_valid", 32'(va), 32'h1);
        sel = 0;
        tick();
        chk("tp_sel0_g", 32'(ga), 32'h1);
        sel = 3;
        tick();
        chk("tp_bad_err", 32'(eb), 32'h1);
        chk("tp_bad_valid", 32'(vb), 32'h0);
        chk("tp_bad_g_hold", 32'(gb), 32'h1);
        chk("tp_bad_cur_hold", 32'(cb), 32'h0);
        sel = 0;
        tick();
        chk("tp_err_pulse_end", 32'(eb), 32'h0);

        mode = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("tp_scan_cur", 32'(ca), 32'(seq[i]));
            chk("tp_scan_wrap", 32'(wa), 32'(i == 8));
            chk("tp_scan_g", 32'(ga), 32'(da[seq[i]*4 +: 4]));
        end

        en = 0;
        tick();
        en = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("tp_pre_drop_cur", 32'(ca), 32'h2);
        held = ga;
        en = 0;
        tick();
        chk("tp_drop_valid", 32'(va), 32'h0);
        chk("tp_drop_g_hold", 32'(ga), 32'(held));
        en = 1;
        tick();
        chk("tp_restart_cur", 32'(ca), 32'h0);

        mode = 0; sel = 1; da = 16'h00A0;
        tick();
        chk("tp_pre_rst_g", 32'(ga), 32'hA);
        #2 rst = 1;
        ma = m_rst(); mb = m_rst();
        #1;
        chk("tp_rst_g", 32'(ga), 32'h0);
        chk("tp_rst_valid", 32'(va), 32'h0);
        chk("tp_rst_cur", 32'(ca), 32'h0);
        check_all();
        @(negedge clk);
        rst = 0;

`ifdef CHAN_SEL_PARITY_EN
        mode = 0; sel = 1; da = 16'h0070;
        tick();
        chk("tp_par_odd", 32'(pa), 32'h1);
        da = 16'h00F0;
        tick();
        chk("tp_par_stuck", 32'(pa), 32'h0);
        chk("tp_stuck_err", 32'(ea), 32'h1);
`endif

        mode = 1;
        for (int i = 0; i < 400; i++) begin
            en = $urandom_range(0, 11) != 0;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel = 2'($urandom);
            da = 16'($urandom);
            db = 12'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
